sps_match_ctrl: RTL and testbench

SPS_MATCH_CTRL -- requirements
Module: sps_match_ctrl

---
 rtl/sps_match_if.sv | 29 ++
 rtl/sps_match_ctrl.sv | 143 ++++++++++++++
 tb/tb_sps_match_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sps_match_if.sv
// sps_match_if: player commit inputs and round/match reporting outputs of the match controller
interface sps_match_if;
  logic       match_start;
  logic [1:0] p1_move;
  logic       p1_commit;
  logic [1:0] p2_move;
  logic       p2_commit;
  logic       p1_locked;
  logic       p2_locked;
  logic       round_valid;
  logic [1:0] round_result;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [7:0] round_count;
  logic       match_done;
  logic [1:0] match_winner;
  logic       timeout_flag;
  logic [2:0] state_o;
  modport master (
    output match_start, p1_move, p1_commit, p2_move, p2_commit,
    input  p1_locked, p2_locked, round_valid, round_result, p1_score, p2_score,
           round_count, match_done, match_winner, timeout_flag, state_o
  );
  modport slave (
    input  match_start, p1_move, p1_commit, p2_move, p2_commit,
    output p1_locked, p2_locked, round_valid, round_result, p1_score, p2_score,
           round_count, match_done, match_winner, timeout_flag, state_o
  );
endinterface

// File: rtl/sps_match_ctrl.sv
// sps_match_ctrl: stone-paper-scissors match controller with commit locks, timeout forfeits and scoring
module sps_match_ctrl #(
  parameter int unsigned WIN_TARGET     = 3,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic        clk,
  input logic        rst_n,
  sps_match_if.slave m
);
  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    COLLECT  = 3'b001,
    EVALUATE = 3'b010,
    REPORT   = 3'b011,
    DONE     = 3'b100
  } state_t;
  localparam logic [3:0]  WIN    = 4'(WIN_TARGET);
  localparam logic [15:0] T_LAST = TIMEOUT_CYCLES - 16'd1;
  state_t      state_q, state_d;
  logic [1:0]  p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
  logic [1:0]  result_q, result_d, winner_q, winner_d;
  logic [1:0]  norm_res, forf_res;
  logic        p1_lk_q, p1_lk_d, p2_lk_q, p2_lk_d;
  logic        forfeit_q, forfeit_d, valid_q, valid_d, tout_q, tout_d, done_q, done_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  p1_sc_q, p1_sc_d, p2_sc_q, p2_sc_d;
  logic [7:0]  count_q, count_d;
  logic        cap1, cap2;
  // stone 00 beats scissors 10, scissors beats paper 01, paper beats stone
  assign norm_res = (p1_mv_q == 2'b11 || p2_mv_q == 2'b11) ? 2'b11 :
                    (p1_mv_q == p2_mv_q) ? 2'b00 :
                    ({p1_mv_q, p2_mv_q} inside {4'b0010, 4'b1001, 4'b0100}) ? 2'b01 : 2'b10;
  assign forf_res = p1_lk_q ? 2'b01 : p2_lk_q ? 2'b10 : 2'b11;
  // next-state and next-output logic; a restart request wins over everything else in COLLECT
  always_comb begin
    state_d   = state_q;
    p1_mv_d   = p1_mv_q;
    p2_mv_d   = p2_mv_q;
    p1_lk_d   = p1_lk_q;
    p2_lk_d   = p2_lk_q;
    forfeit_d = forfeit_q;
    timer_d   = timer_q;
    result_d  = result_q;
    valid_d   = valid_q;
    tout_d    = tout_q;
    p1_sc_d   = p1_sc_q;
    p2_sc_d   = p2_sc_q;
    count_d   = count_q;
    done_d    = done_q;
    winner_d  = winner_q;
    cap1      = state_q == COLLECT && !m.match_start && m.p1_commit && !p1_lk_q;
    cap2      = state_q == COLLECT && !m.match_start && m.p2_commit && !p2_lk_q;
    if (m.match_start && (state_q == IDLE || state_q == COLLECT || state_q == DONE)) begin
      state_d   = COLLECT;
      p1_mv_d   = '0;
      p2_mv_d   = '0;
      p1_lk_d   = 1'b0;
      p2_lk_d   = 1'b0;
      forfeit_d = 1'b0;
      timer_d   = '0;
      p1_sc_d   = '0;
      p2_sc_d   = '0;
      count_d   = '0;
      done_d    = 1'b0;
      winner_d  = 2'b00;
    end else if (state_q == COLLECT) begin
      p1_lk_d   = p1_lk_q | cap1;
      p2_lk_d   = p2_lk_q | cap2;
      p1_mv_d   = cap1 ? m.p1_move : p1_mv_q;
      p2_mv_d   = cap2 ? m.p2_move : p2_mv_q;
      timer_d   = timer_q + 16'd1;
      forfeit_d = !(p1_lk_d && p2_lk_d);
      state_d   = ((p1_lk_q && p2_lk_q) || timer_q == T_LAST) ? EVALUATE : COLLECT;
    end else if (state_q == EVALUATE) begin
      result_d = forfeit_q ? forf_res : norm_res;
      valid_d  = 1'b1;
      tout_d   = forfeit_q;
      p1_sc_d  = p1_sc_q + 4'(result_d == 2'b01);
      p2_sc_d  = p2_sc_q + 4'(result_d == 2'b10);
      count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      state_d  = REPORT;
    end else if (state_q == REPORT) begin
      valid_d   = 1'b0;
      tout_d    = 1'b0;
      done_d    = p1_sc_q == WIN || p2_sc_q == WIN;
      winner_d  = (p1_sc_q == WIN) ? 2'b01 : (p2_sc_q == WIN) ? 2'b10 : 2'b00;
      state_d   = done_d ? DONE : COLLECT;
      p1_lk_d   = 1'b0;
      p2_lk_d   = 1'b0;
      p1_mv_d   = '0;
      p2_mv_d   = '0;
      forfeit_d = 1'b0;
      timer_d   = '0;
    end
  end
  // all state and outputs are registered and cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p1_mv_q   <= '0;
      p2_mv_q   <= '0;
      p1_lk_q   <= 1'b0;
      p2_lk_q   <= 1'b0;
      forfeit_q <= 1'b0;
      timer_q   <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      tout_q    <= 1'b0;
      p1_sc_q   <= '0;
      p2_sc_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      p1_mv_q   <= p1_mv_d;
      p2_mv_q   <= p2_mv_d;
      p1_lk_q   <= p1_lk_d;
      p2_lk_q   <= p2_lk_d;
      forfeit_q <= forfeit_d;
      timer_q   <= timer_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      tout_q    <= tout_d;
      p1_sc_q   <= p1_sc_d;
      p2_sc_q   <= p2_sc_d;
      count_q   <= count_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
    end
  end
  assign m.p1_locked    = p1_lk_q;
  assign m.p2_locked    = p2_lk_q;
  assign m.round_valid  = valid_q;
  assign m.round_result = result_q;
  assign m.p1_score     = p1_sc_q;
  assign m.p2_score     = p2_sc_q;
  assign m.round_count  = count_q;
  assign m.match_done   = done_q;
  assign m.match_winner = winner_q;
  assign m.timeout_flag = tout_q;
  assign m.state_o      = state_q;
endmodule

// File: tb/tb_sps_match_ctrl.sv
// tb_sps_match_ctrl: randomized and directed rounds checked against a round-level timing and scoring model
module tb_sps_match_ctrl;
  localparam int T = 4;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int s1, s2, rc;
  logic [27:0] outs;
  sps_match_if bus();
  sps_match_ctrl #(.WIN_TARGET(W), .TIMEOUT_CYCLES(16'(T))) dut (.clk(clk), .rst_n(rst_n), .m(bus));
  assign outs = {bus.state_o, bus.p1_locked, bus.p2_locked, bus.round_valid, bus.round_result,
                 bus.p1_score, bus.p2_score, bus.round_count, bus.match_done, bus.match_winner,
                 bus.timeout_flag};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int judge(input int a, input int b);
    if (a == 3 || b == 3) return 3;
    if (a == b) return 0;
    return ((a + 2) % 3 == b) ? 1 : 2;
  endfunction
  task automatic drive(input bit st, input bit c1, input int mv1, input bit c2, input int mv2);
    bus.match_start = st;
    bus.p1_commit   = c1;
    bus.p1_move     = 2'(mv1);
    bus.p2_commit   = c2;
    bus.p2_move     = 2'(mv2);
  endtask
  task automatic start_match();
    drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    s1 = 0; s2 = 0; rc = 0;
    chk("start_state", int'(bus.state_o), 1);
    chk("start_scores", int'({bus.p1_score, bus.p2_score}), 0);
    chk("start_count", int'(bus.round_count), 0);
    chk("start_locks", int'({bus.p1_locked, bus.p2_locked}), 0);
    chk("start_done", int'({bus.match_done, bus.match_winner}), 0);
  endtask
  // d1/d2: COLLECT cycle index of each player's first commit (>= T means never in time)
  task automatic run_round(input int d1, input int d2, input int m1, input int m2);
    int ev, rep, er, eto, st;
    bit l1, l2;
    l1 = d1 < T;
    l2 = d2 < T;
    if (l1 && l2) begin
      ev = ((d1 > d2) ? d1 : d2) + 2;
      if (ev > T) ev = T;
      er = judge(m1, m2);
      eto = 0;
    end else begin
      ev = T;
      er = l1 ? 1 : l2 ? 2 : 3;
      eto = 1;
    end
    rep = ev + 1;
    if (er == 1) s1++;
    if (er == 2) s2++;
    if (rc < 255) rc++;
    for (int k = 0; k <= rep; k++) begin
      drive(1'b0,
            (k == d1) || (k > d1 && $urandom_range(0, 1) == 1), (k == d1) ? m1 : int'($urandom_range(0, 3)),
            (k == d2) || (k > d2 && $urandom_range(0, 1) == 1), (k == d2) ? m2 : int'($urandom_range(0, 3)));
      @(negedge clk);
      st = (k < ev) ? 1 : (k == ev) ? 2 : 3;
      chk("round_state", int'(bus.state_o), st);
      chk("round_valid", int'(bus.round_valid), int'(k == rep));
      chk("timeout_flag", int'(bus.timeout_flag), (k == rep) ? eto : 0);
      chk("p1_locked", int'(bus.p1_locked), int'(l1 && k > d1));
      chk("p2_locked", int'(bus.p2_locked), int'(l2 && k > d2));
      if (k == rep) begin
        chk("round_result", int'(bus.round_result), er);
        chk("p1_score", int'(bus.p1_score), s1);
        chk("p2_score", int'(bus.p2_score), s2);
        chk("round_count", int'(bus.round_count), rc);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic after_round();
    if (s1 == W || s2 == W) begin
      chk("done_state", int'(bus.state_o), 4);
      chk("match_done", int'(bus.match_done), 1);
      chk("match_winner", int'(bus.match_winner), (s1 == W) ? 1 : 2);
      repeat (2) begin
        drive(1'b0, 1'b1, int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)));
        @(posedge clk); #1;
        chk("done_hold_state", int'(bus.state_o), 4);
        chk("done_hold_scores", int'({bus.p1_score, bus.p2_score}), int'({4'(s1), 4'(s2)}));
        chk("done_hold_count", int'(bus.round_count), rc);
        chk("done_hold_winner", int'(bus.match_winner), (s1 == W) ? 1 : 2);
        chk("done_valid", int'(bus.round_valid), 0);
      end
      start_match();
    end else begin
      chk("next_collect", int'(bus.state_o), 1);
      chk("no_winner", int'({bus.match_done, bus.match_winner}), 0);
    end
  endtask
  task automatic idle_hold();
    repeat (3) begin
      drive(1'b0, 1'b1, int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)));
      @(posedge clk); #1;
      chk("idle_state", int'(bus.state_o), 0);
      chk("idle_locks", int'({bus.p1_locked, bus.p2_locked}), 0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    #2 chk("reset_outputs_init", int'(outs), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_hold();
    start_match();
    run_round(0, 0, 1, 0);
    after_round();
    drive(1'b0, 1'b1, 0, 1'b0, 0);
    @(posedge clk); #1;
    chk("pre_restart_lock", int'(bus.p1_locked), 1);
    drive(1'b1, 1'b1, 1, 1'b1, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    chk("restart_state", int'(bus.state_o), 1);
    chk("restart_locks", int'({bus.p1_locked, bus.p2_locked}), 0);
    chk("restart_p1_score", int'(bus.p1_score), 0);
    chk("restart_count", int'(bus.round_count), 0);
    s1 = 0; s2 = 0; rc = 0;
    run_round(0, 0, 2, 2); after_round();
    run_round(1, 0, 3, 0); after_round();
    run_round(9, 1, 0, 2); after_round();
    run_round(9, 9, 0, 0); after_round();
    run_round(3, 9, 1, 0); after_round();
    run_round(3, 1, 0, 2); after_round();
    run_round(0, 2, 0, 2); after_round();
    run_round(2, 0, 2, 1); after_round();
    drive(1'b0, 1'b1, 0, 1'b0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1, 1'b0, 0);
    chk("mid_lock_p1", int'(bus.p1_locked), 1);
    @(posedge clk); #1;
    chk("mid_lock_hold", int'(bus.p1_locked), 1);
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs_mid", int'(outs), 0);
    @(posedge clk); #1;
    chk("reset_outputs_held", int'(outs), 0);
    rst_n = 1'b1;
    idle_hold();
    start_match();
    repeat (60) begin
      run_round(int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      after_round();
    end
    start_match();
    repeat (258) begin
      int mv;
      mv = int'($urandom_range(0, 3));
      run_round(0, 0, mv, mv);
      after_round();
    end
    chk("count_saturated", int'(bus.round_count), 255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
